// File: rtl/zerosoc_padctrl.sv
// Programmable pad controller: per-pad function select, electrical cfg,
// optional input glitch filter and a sticky configuration lock, sitting
// between the zerosoc core (GPIO, UART) and the padring.
module zerosoc_padctrl #(
  parameter int NUM_PADS    = 34,
  parameter int NUM_GPIO    = 32,
  parameter int CFG_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int UART_TX_PAD = 32,
  parameter int UART_RX_PAD = 33,
  parameter int AW          = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      reg_req_i,
  input  logic                      reg_we_i,
  input  logic [AW-1:0]             reg_addr_i,
  input  logic [31:0]               reg_wdata_i,
  output logic [31:0]               reg_rdata_o,
  output logic                      reg_rvalid_o,
  output logic                      reg_err_o,
  input  logic [NUM_GPIO-1:0]       gpio_o_i,
  input  logic [NUM_GPIO-1:0]       gpio_en_i,
  output logic [NUM_GPIO-1:0]       gpio_i_o,
  input  logic                      uart_tx_i,
  input  logic                      uart_tx_en_i,
  output logic                      uart_rx_o,
  input  logic [NUM_PADS-1:0]       pad_din_i,
  output logic [NUM_PADS-1:0]       pad_dout_o,
  output logic [NUM_PADS-1:0]       pad_oen_o,
  output logic [NUM_PADS-1:0]       pad_ie_o,
  output logic [NUM_PADS*CFG_W-1:0] pad_cfg_o
);

  localparam int CNT_W = $clog2(FILT_CYCLES + 1);

  localparam logic [1:0] FUNC_GPIO    = 2'd0;
  localparam logic [1:0] FUNC_UART_TX = 2'd1;
  localparam logic [1:0] FUNC_UART_RX = 2'd2;
  localparam logic [1:0] FUNC_OFF     = 2'd3;

  localparam logic [AW-1:0]    LOCK_ADDR = AW'(NUM_PADS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FILT_CYCLES - 1);

  // The UART RX pad idles high, so its input path starts at 1 to avoid a
  // spurious start bit right after reset.
  localparam logic [NUM_PADS-1:0] IN_RST = NUM_PADS'(1) << UART_RX_PAD;

  function automatic logic [1:0] func_rst(input int k);
    if (k == UART_TX_PAD)      return FUNC_UART_TX;
    else if (k == UART_RX_PAD) return FUNC_UART_RX;
    else if (k < NUM_GPIO)     return FUNC_GPIO;
    else                       return FUNC_OFF;
  endfunction

  logic [NUM_PADS-1:0][CFG_W-1:0]       cfg_q;
  logic [NUM_PADS-1:0][1:0]             func_q;
  logic [NUM_PADS-1:0]                  filt_en_q;
  logic                                 lock_q;

  logic [NUM_PADS-1:0][SYNC_STAGES-1:0] sync_q;
  logic [NUM_PADS-1:0][CNT_W-1:0]       cnt_q;
  logic [NUM_PADS-1:0]                  filt_q;
  logic [NUM_PADS-1:0]                  synced;
  logic [NUM_PADS-1:0]                  eff_in;

  logic [NUM_PADS-1:0]                  dout_d;
  logic [NUM_PADS-1:0]                  oen_d;
  logic [NUM_PADS-1:0]                  ie_d;

  logic        is_pad;
  logic        is_lock;
  logic        is_bad;
  logic        err_d;
  logic        pad_wr;
  logic [31:0] rdata_d;
  logic        unused_wdata;

  assign is_pad  = reg_addr_i <  LOCK_ADDR;
  assign is_lock = reg_addr_i == LOCK_ADDR;
  assign is_bad  = reg_addr_i >  LOCK_ADDR;
  assign err_d   = is_bad | (reg_we_i & is_pad & lock_q);
  assign pad_wr  = reg_req_i & reg_we_i & is_pad & ~lock_q;

  assign unused_wdata = ^reg_wdata_i[31:11];

  // Read data mux; writes and errored accesses return zero.
  always_comb begin
    rdata_d = '0;
    if (!reg_we_i) begin
      if (is_lock) rdata_d[0] = lock_q;
      for (int k = 0; k < NUM_PADS; k++) begin
        if (reg_addr_i == AW'(k)) begin
          rdata_d[CFG_W-1:0] = cfg_q[k];
          rdata_d[9:8]       = func_q[k];
          rdata_d[10]        = filt_en_q[k];
        end
      end
    end
  end

  // Bus response register: one-cycle response for every request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_rvalid_o <= 1'b0;
      reg_err_o    <= 1'b0;
      reg_rdata_o  <= '0;
    end else begin
      reg_rvalid_o <= reg_req_i;
      reg_err_o    <= reg_req_i & err_d;
      reg_rdata_o  <= (reg_req_i && !err_d) ? rdata_d : '0;
    end
  end

  // Per-pad configuration registers and the sticky lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_PADS; k++) begin
        cfg_q[k]     <= '0;
        func_q[k]    <= func_rst(k);
        filt_en_q[k] <= 1'b0;
      end
      lock_q <= 1'b0;
    end else begin
      if (pad_wr) begin
        for (int k = 0; k < NUM_PADS; k++) begin
          if (reg_addr_i == AW'(k)) begin
            cfg_q[k]     <= reg_wdata_i[CFG_W-1:0];
            func_q[k]    <= reg_wdata_i[9:8];
            filt_en_q[k] <= reg_wdata_i[10];
          end
        end
      end
      if (reg_req_i && reg_we_i && is_lock && reg_wdata_i[0]) lock_q <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_PADS; k++) begin : g_pad
    logic gpio_sel;
    logic gpio_do;
    logic gpio_oe;

    if (k < NUM_GPIO) begin : g_gpio
      assign gpio_sel    = func_q[k] == FUNC_GPIO;
      assign gpio_do     = gpio_o_i[k];
      assign gpio_oe     = gpio_en_i[k];
      assign gpio_i_o[k] = eff_in[k] & gpio_sel;
    end else begin : g_no_gpio
      assign gpio_sel = 1'b0;
      assign gpio_do  = 1'b0;
      assign gpio_oe  = 1'b0;
    end

    assign dout_d[k] = (func_q[k] == FUNC_UART_TX) ? uart_tx_i     : (gpio_sel & gpio_do);
    assign oen_d[k]  = (func_q[k] == FUNC_UART_TX) ? ~uart_tx_en_i : ~(gpio_sel & gpio_oe);
    assign ie_d[k]   = (func_q[k] == FUNC_UART_RX) | gpio_sel;

    assign pad_cfg_o[k*CFG_W +: CFG_W] = cfg_q[k];
    assign synced[k] = sync_q[k][SYNC_STAGES-1];
  end

  // Registered pad outputs, all drivers disabled while in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pad_dout_o <= '0;
      pad_oen_o  <= '1;
      pad_ie_o   <= '0;
    end else begin
      pad_dout_o <= dout_d;
      pad_oen_o  <= oen_d;
      pad_ie_o   <= ie_d;
    end
  end

  // Input synchronisers and glitch filters. With the filter disabled the
  // filter flop shadows the synced value and the counter stays cleared, so
  // enabling the filter later starts from a clean state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_PADS; k++) begin
        sync_q[k] <= {SYNC_STAGES{IN_RST[k]}};
        cnt_q[k]  <= '0;
      end
      filt_q <= IN_RST;
    end else begin
      for (int k = 0; k < NUM_PADS; k++) begin
        sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], pad_din_i[k]};
        if (!filt_en_q[k]) begin
          filt_q[k] <= synced[k];
          cnt_q[k]  <= '0;
        end else if (synced[k] == filt_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] >= CNT_LAST) begin
          filt_q[k] <= synced[k];
          cnt_q[k]  <= '0;
        end else begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign eff_in = (filt_en_q & filt_q) | (~filt_en_q & synced);

  // UART RX comes from the lowest-index pad selected as UART_RX; idle high otherwise.
  always_comb begin
    uart_rx_o = 1'b1;
    for (int k = NUM_PADS - 1; k >= 0; k--) begin
      if (func_q[k] == FUNC_UART_RX) uart_rx_o = eff_in[k];
    end
  end

endmodule

// File: tb/tb_zerosoc_padctrl.sv
// Self-checking bench for zerosoc_padctrl: scoreboarded register bus plus
// directed and randomised pad-path checks against a behavioural model.
module tb_zerosoc_padctrl;

  localparam int NUM_PADS = 34;
  localparam int NUM_GPIO = 32;
  localparam int CFG_W    = 8;
  localparam int AW       = 6;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      reg_req = 1'b0;
  logic                      reg_we = 1'b0;
  logic [AW-1:0]             reg_addr = '0;
  logic [31:0]               reg_wdata = '0;
  logic [31:0]               reg_rdata_o;
  logic                      reg_rvalid_o;
  logic                      reg_err_o;
  logic [NUM_GPIO-1:0]       gpio_o = '0;
  logic [NUM_GPIO-1:0]       gpio_en = '0;
  logic [NUM_GPIO-1:0]       gpio_i_o;
  logic                      uart_tx = 1'b0;
  logic                      uart_tx_en = 1'b0;
  logic                      uart_rx_o;
  logic [NUM_PADS-1:0]       din = '0;
  logic [NUM_PADS-1:0]       pad_dout_o;
  logic [NUM_PADS-1:0]       pad_oen_o;
  logic [NUM_PADS-1:0]       pad_ie_o;
  logic [NUM_PADS*CFG_W-1:0] pad_cfg_o;

  zerosoc_padctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .reg_req_i    (reg_req),
    .reg_we_i     (reg_we),
    .reg_addr_i   (reg_addr),
    .reg_wdata_i  (reg_wdata),
    .reg_rdata_o  (reg_rdata_o),
    .reg_rvalid_o (reg_rvalid_o),
    .reg_err_o    (reg_err_o),
    .gpio_o_i     (gpio_o),
    .gpio_en_i    (gpio_en),
    .gpio_i_o     (gpio_i_o),
    .uart_tx_i    (uart_tx),
    .uart_tx_en_i (uart_tx_en),
    .uart_rx_o    (uart_rx_o),
    .pad_din_i    (din),
    .pad_dout_o   (pad_dout_o),
    .pad_oen_o    (pad_oen_o),
    .pad_ie_o     (pad_ie_o),
    .pad_cfg_o    (pad_cfg_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_read;
    logic        err;
    logic [31:0] data;
    int          addr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Reference model of the register file, in plain field form.
  logic [CFG_W-1:0] m_cfg  [NUM_PADS];
  logic [1:0]       m_func [NUM_PADS];
  logic             m_filt [NUM_PADS];
  logic             m_lock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_PADS; k++) begin
      m_cfg[k]  = '0;
      m_filt[k] = 1'b0;
      if (k == 32)           m_func[k] = 2'd1;
      else if (k == 33)      m_func[k] = 2'd2;
      else if (k < NUM_GPIO) m_func[k] = 2'd0;
      else                   m_func[k] = 2'd3;
    end
    m_lock = 1'b0;
  endtask

  task automatic bus(input logic we, input int addr, input logic [31:0] wdata);
    exp_t e;
    @(negedge clk);
    reg_req   = 1'b1;
    reg_we    = we;
    reg_addr  = AW'(addr);
    reg_wdata = wdata;
    e.is_read = !we;
    e.err     = 1'b0;
    e.data    = '0;
    e.addr    = addr;
    if (addr > NUM_PADS) begin
      e.err = 1'b1;
    end else if (addr == NUM_PADS) begin
      if (we) begin
        if (wdata[0]) m_lock = 1'b1;
      end else begin
        e.data = {31'b0, m_lock};
      end
    end else if (we) begin
      if (m_lock) e.err = 1'b1;
      else begin
        m_cfg[addr]  = wdata[7:0];
        m_func[addr] = wdata[9:8];
        m_filt[addr] = wdata[10];
      end
    end else begin
      e.data = {21'b0, m_filt[addr], m_func[addr], m_cfg[addr]};
    end
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n = 1);
    @(negedge clk);
    reg_req = 1'b0;
    reg_we  = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // Response monitor: every request must be answered on the following edge.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (reg_rvalid_o) begin
        if (sb_q.size() == 0) chk("unexpected_rvalid", 1, 0);
        else begin
          mon_e = sb_q.pop_front();
          chk($sformatf("rsp_err[a=%0d]", mon_e.addr), reg_err_o, mon_e.err);
          if (mon_e.is_read || mon_e.err)
            chk($sformatf("rsp_rdata[a=%0d]", mon_e.addr), reg_rdata_o, mon_e.data);
        end
      end else if (sb_q.size() != 0) begin
        chk("missing_rvalid", 0, 1);
        void'(sb_q.pop_front());
      end
    end
  end

  // Compare all pad-side and core-side outputs with the model, assuming the
  // pad inputs have been stable long enough for any filter to settle.
  task automatic check_outputs(input string tag);
    logic [NUM_PADS-1:0]       ed, eo, ei;
    logic [NUM_PADS*CFG_W-1:0] ec;
    logic [NUM_GPIO-1:0]       eg;
    logic                      erx, found;
    found = 1'b0;
    erx   = 1'b1;
    for (int k = 0; k < NUM_PADS; k++) begin
      ed[k] = 1'b0; eo[k] = 1'b1; ei[k] = 1'b0;
      if (m_func[k] == 2'd0 && k < NUM_GPIO) begin
        ed[k] = gpio_o[k]; eo[k] = ~gpio_en[k]; ei[k] = 1'b1;
      end else if (m_func[k] == 2'd1) begin
        ed[k] = uart_tx; eo[k] = ~uart_tx_en;
      end else if (m_func[k] == 2'd2) begin
        ei[k] = 1'b1;
        if (!found) begin erx = din[k]; found = 1'b1; end
      end
      ec[k*CFG_W +: CFG_W] = m_cfg[k];
      if (k < NUM_GPIO) eg[k] = (m_func[k] == 2'd0) ? din[k] : 1'b0;
    end
    chk({tag, "_dout"}, pad_dout_o, ed);
    chk({tag, "_oen"},  pad_oen_o,  eo);
    chk({tag, "_ie"},   pad_ie_o,   ei);
    chk({tag, "_gpio_i"}, gpio_i_o, eg);
    chk({tag, "_uart_rx"}, uart_rx_o, erx);
    checks++;
    if (pad_cfg_o !== ec) begin
      errors++;
      $display("FAIL %s_cfg: got 0x%0h expected 0x%0h", tag, pad_cfg_o, ec);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rvalid"}, reg_rvalid_o, 0);
    chk({tag, "_oen"}, pad_oen_o, {NUM_PADS{1'b1}});
    chk({tag, "_ie"}, pad_ie_o, 0);
    chk({tag, "_dout"}, pad_dout_o, 0);
    chk({tag, "_uart_rx"}, uart_rx_o, 1);
    chk({tag, "_cfg_zero"}, (pad_cfg_o == '0), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int a;

    // Reset and reset-value reads
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    rst_n = 1'b1;
    bus(0, 32, 0);
    bus(0, 33, 0);
    bus(0, 0, 0);
    bus(0, NUM_PADS, 0);
    bus(0, 35, 0);
    bus(0, 63, 0);
    idle(3);
    chk("uart_rx_idle_low", uart_rx_o, 0);

    // GPIO output path, one cycle from core to pad
    gpio_en[3] = 1'b1;
    gpio_o[3]  = 1'b1;
    @(negedge clk);
    chk("gpio3_oen_on", pad_oen_o[3], 0);
    chk("gpio3_dout", pad_dout_o[3], 1);
    chk("gpio3_ie", pad_ie_o[3], 1);
    gpio_en[3] = 1'b0;
    @(negedge clk);
    chk("gpio3_oen_off", pad_oen_o[3], 1);

    // Unfiltered input latency on pad 4
    din[4] = 1'b1;
    @(negedge clk);
    chk("unfilt_lat1", gpio_i_o[4], 0);
    @(negedge clk);
    chk("unfilt_lat2", gpio_i_o[4], 1);
    din[4] = 1'b0;

    // Glitch filter on pad 7: 3-cycle pulse rejected, 6-cycle pulse passes
    bus(1, 7, 32'h400);
    idle(4);
    din[7] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 3) din[7] = 1'b0;
      chk($sformatf("filt_short_c%0d", c), gpio_i_o[7], 0);
    end
    din[7] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("filt_long_c%0d", c), gpio_i_o[7], (c >= 6) ? 1 : 0);
      if (c == 6) din[7] = 1'b0;
    end
    idle(10);
    chk("filt_fall", gpio_i_o[7], 0);

    // Remap pad 5 to UART TX with cfg 0xAB
    bus(1, 5, 32'h1AB);
    idle(1);
    uart_tx_en = 1'b1;
    din[5] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      uart_tx = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk($sformatf("tx5_dout_%0d", i), pad_dout_o[5], uart_tx);
      chk($sformatf("tx32_dout_%0d", i), pad_dout_o[32], uart_tx);
      chk($sformatf("tx5_oen_%0d", i), pad_oen_o[5], 0);
    end
    chk("pad5_cfg", pad_cfg_o[5*CFG_W +: CFG_W], 8'hAB);
    chk("pad5_gpio_i", gpio_i_o[5], 0);

    // UART RX selection
    bus(1, 33, 32'h300);
    idle(1);
    chk("rx_none", uart_rx_o, 1);
    din[10] = 1'b0;
    din[33] = 1'b1;
    bus(1, 33, 32'h200);
    bus(1, 10, 32'h200);
    idle(4);
    chk("rx_lowest", uart_rx_o, 0);
    check_outputs("remap");

    // Lock behaviour, then reset mid-traffic releases it
    bus(1, NUM_PADS, 0);
    bus(1, 0, 32'h005);
    bus(1, NUM_PADS, 1);
    bus(1, 0, 32'h3FF);
    bus(0, 0, 0);
    bus(1, NUM_PADS, 0);
    bus(0, NUM_PADS, 0);
    bus(0, 2, 0);
    #2;
    rst_n = 1'b0;
    reg_req = 1'b0;
    sb_q.delete();
    model_reset();
    #1;
    check_reset_state("mid");
    @(negedge clk);
    rst_n = 1'b1;
    bus(0, NUM_PADS, 0);
    bus(1, 0, 32'h3FF);
    bus(0, 0, 0);

    // Bus edges: out-of-range read, write then immediate read
    bus(0, 35, 0);
    v = $urandom & 32'h7FF;
    bus(1, 2, v);
    bus(0, 2, 0);
    bus(1, 0, 32'h000);
    idle(8);
    check_outputs("post_lock");

    // Randomised configuration and pad traffic
    for (int it = 0; it < 40; it++) begin
      for (int j = 0; j < 4; j++) begin
        a = $urandom_range(0, NUM_PADS - 1);
        bus(1, a, $urandom);
        bus(0, $urandom_range(0, 40), 0);
      end
      idle(1);
      gpio_o     = $urandom;
      gpio_en    = $urandom;
      uart_tx    = 1'($urandom_range(0, 1));
      uart_tx_en = 1'($urandom_range(0, 1));
      din        = {2'($urandom), 32'($urandom)};
      repeat (8) @(negedge clk);
      check_outputs($sformatf("rnd%0d", it));
    end

    for (int w = 0; w < 5 && sb_q.size() != 0; w++) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
